// File: rtl/measurement_sequencer_pkg.sv
// Shared definitions for the measurement sequencer and the MAJOR/MINOR counter core.
// Optional feature macro used by this slice: MEASUREMENT_SEQUENCER_TIMEOUT_EN.
package measurement_sequencer_pkg;

    // Widths shared with the counter core
    localparam int UPCOUNT_WIDTH   = 34;
    localparam int DOWNCOUNT_WIDTH = 8;
    localparam int TAG_WIDTH       = 4;

    // Default abort limit in MAJOR_CLOCK cycles when the timeout feature is built in
    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd67108864;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARMWAIT,
        ST_MEASURE,
        ST_CAPTURE
    } seq_state_e;

    // A count of all ones means the core's up-counter has saturated
    function automatic logic isSaturated(input logic [UPCOUNT_WIDTH-1:0] count);
        return &count;
    endfunction

endpackage

// File: rtl/seq_result_reg.sv
// One-deep result register with valid/ready handshake and sticky overrun flag.
// A capture is accepted when the register is empty or is being drained in the same
// cycle; otherwise the new result is dropped and overrun is raised.
module seq_result_reg
    import measurement_sequencer_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     capture_i,
    input  logic [UPCOUNT_WIDTH-1:0] data_i,
    input  logic [TAG_WIDTH-1:0]     tag_i,
    input  logic                     sat_i,
    input  logic                     ready_i,
    output logic [UPCOUNT_WIDTH-1:0] data_o,
    output logic [TAG_WIDTH-1:0]     tag_o,
    output logic                     sat_o,
    output logic                     valid_o,
    output logic                     overrun_o
);

    logic [UPCOUNT_WIDTH-1:0] data_q;
    logic [TAG_WIDTH-1:0]     tag_q;
    logic                     sat_q;
    logic                     valid_q;
    logic                     overrun_q;

    logic transfer;
    logic acceptCapture;
    logic dropCapture;

    assign transfer      = valid_q && ready_i;
    assign acceptCapture = capture_i && (!valid_q || ready_i);
    assign dropCapture   = capture_i && valid_q && !ready_i;

    // Hold one result; a same-cycle capture refills the slot being drained
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q    <= '0;
            tag_q     <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (acceptCapture) begin
                data_q  <= data_i;
                tag_q   <= tag_i;
                sat_q   <= sat_i;
                valid_q <= 1'b1;
            end else if (transfer) begin
                valid_q <= 1'b0;
            end

            if (dropCapture) begin
                overrun_q <= 1'b1;
            end else if (transfer) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign data_o    = data_q;
    assign tag_o     = tag_q;
    assign sat_o     = sat_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/measurement_sequencer.sv
// Sequencer for the MAJOR/MINOR clock-ratio counter core: loads the gate length,
// waits for the core to finish, and captures the major-cycle count with a tag.
// Define MEASUREMENT_SEQUENCER_TIMEOUT_EN to abort stalled measurements after
// TIMEOUT_CYCLES MAJOR_CLOCK cycles and expose a sticky timeout output.
module measurement_sequencer
    import measurement_sequencer_pkg::*;
`ifdef MEASUREMENT_SEQUENCER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
`endif
(
    input  logic                       MAJOR_CLOCK,
    input  logic                       RESET,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       continuous,
    input  logic [DOWNCOUNT_WIDTH-1:0] cfg_periods,
    output logic                       cnt_load,
    output logic [DOWNCOUNT_WIDTH-1:0] cnt_periods,
    input  logic                       cnt_done,
    input  logic [UPCOUNT_WIDTH-1:0]   cnt_upcount,
    output logic [UPCOUNT_WIDTH-1:0]   result_data,
    output logic [TAG_WIDTH-1:0]       result_tag,
    output logic                       result_sat,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic                       overrun,
    output logic                       cfg_error,
    output logic                       busy,
`ifdef MEASUREMENT_SEQUENCER_TIMEOUT_EN
    output logic                       timeout,
`endif
    output logic                       FPGA_INT
);

    seq_state_e                 state_q;
    logic [DOWNCOUNT_WIDTH-1:0] periods_q;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic                       cntLoad_q;
    logic                       busy_q;
    logic                       cfgError_q;
    logic                       captureEn;
    logic                       timeoutHit;

`ifdef MEASUREMENT_SEQUENCER_TIMEOUT_EN
    localparam int TIMER_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TIMER_WIDTH-1:0] timer_q;
    logic                   timeout_q;

    assign timeoutHit = (timer_q == TIMER_WIDTH'(TIMEOUT_CYCLES - 1));
    assign timeout    = timeout_q;
`else
    assign timeoutHit = 1'b0;
`endif

    // A stop in the capture cycle discards that measurement entirely
    assign captureEn = (state_q == ST_CAPTURE) && !stop;

    // Measurement sequencing: stop has priority over every other transition
    always_ff @(posedge MAJOR_CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            periods_q  <= '0;
            tag_q      <= '0;
            cntLoad_q  <= 1'b0;
            busy_q     <= 1'b0;
            cfgError_q <= 1'b0;
`ifdef MEASUREMENT_SEQUENCER_TIMEOUT_EN
            timer_q    <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            cntLoad_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
`ifdef MEASUREMENT_SEQUENCER_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        if (cfg_periods != '0) begin
                            periods_q  <= cfg_periods;
                            cfgError_q <= 1'b0;
                            cntLoad_q  <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= ST_LOAD;
                        end else begin
                            cfgError_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
`ifdef MEASUREMENT_SEQUENCER_TIMEOUT_EN
                    timer_q <= '0;
`endif
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_ARMWAIT;
                    end
                end
                ST_ARMWAIT, ST_MEASURE: begin
`ifdef MEASUREMENT_SEQUENCER_TIMEOUT_EN
                    timer_q <= timer_q + 1'b1;
`endif
                    if (stop) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (timeoutHit) begin
`ifdef MEASUREMENT_SEQUENCER_TIMEOUT_EN
                        timeout_q <= 1'b1;
`endif
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if ((state_q == ST_ARMWAIT) && !cnt_done) begin
                        state_q <= ST_MEASURE;
                    end else if ((state_q == ST_MEASURE) && cnt_done) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (!stop) begin
                        tag_q <= tag_q + 1'b1;
                    end
                    if (continuous && !stop) begin
                        cntLoad_q <= 1'b1;
                        state_q   <= ST_LOAD;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    seq_result_reg u_result (
        .clk_i     (MAJOR_CLOCK),
        .rst_i     (RESET),
        .capture_i (captureEn),
        .data_i    (cnt_upcount),
        .tag_i     (tag_q),
        .sat_i     (isSaturated(cnt_upcount)),
        .ready_i   (result_ready),
        .data_o    (result_data),
        .tag_o     (result_tag),
        .sat_o     (result_sat),
        .valid_o   (result_valid),
        .overrun_o (overrun)
    );

    assign cnt_load    = cntLoad_q;
    assign cnt_periods = periods_q;
    assign busy        = busy_q;
    assign cfg_error   = cfgError_q;
    assign FPGA_INT    = result_valid;

endmodule
